// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      HUNT,
      LEN,
      PAYLOAD,
      CHK,
      DRAIN
   } state_t;

   localparam logic [1:0] ERR_LEN = 2'b01;
   localparam logic [1:0] ERR_CHK = 2'b10;
   localparam logic [1:0] ERR_TMO = 2'b11;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Payload stream from the frame receiver to the command logic (valid/ready).
interface uart_frame_rx_if;

   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;

   modport master (output m_data, m_valid, m_last, input m_ready);
   modport slave  (input m_data, m_valid, m_last, output m_ready);

endinterface

// File: rtl/uart_frame_rx_frame_buf.sv
// Payload buffer: MAX_LEN x 8 registers, synchronous write, combinational read,
// with its own write and read pointers.
module frame_buf #(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned PW      = $clog2(MAX_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_clr,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          rd_clr,
   input  logic          rd_inc,
   output logic [PW-1:0] wr_ptr,
   output logic [PW-1:0] rd_ptr,
   output logic [7:0]    rd_data
);

   localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0] mem [MAX_LEN];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_clr)     wr_ptr <= '0;
         else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_clr)      rd_ptr <= '0;
         else if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed-packet receiver: SOF, LEN, payload, CHK; releases verified payloads.
// Optional UART_FRAME_STATS_EN adds saturating good/bad frame counters.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SOF_BYTE     = SOF_DEFAULT,
   parameter int unsigned TIMEOUT_CLKS = 17360
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_byte,
   input  logic              rx_dv,
   uart_frame_rx_if.master   m_if,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic              rx_overrun,
   output logic              busy
`ifdef UART_FRAME_STATS_EN
   ,
   output logic [15:0]       good_cnt,
   output logic [15:0]       bad_cnt
`endif
);

   localparam int unsigned PW = $clog2(MAX_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

   state_t        state;
   logic [PW-1:0] len;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [7:0]    sum;
   logic [7:0]    rd_data;
   logic [TW-1:0] tmo_cnt;

   logic in_frame, len_bad, chk_ok, tmo_hit, handshake;

   assign in_frame  = state inside {LEN, PAYLOAD, CHK};
   assign len_bad   = (rx_byte == 8'd0) || (rx_byte > 8'(MAX_LEN));
   assign chk_ok    = (rx_byte == sum);
   assign tmo_hit   = in_frame && !rx_dv && (tmo_cnt == TW'(TIMEOUT_CLKS - 1));
   assign handshake = m_if.m_valid && m_if.m_ready;

   frame_buf #(.MAX_LEN(MAX_LEN), .PW(PW)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_clr  ((state == LEN) && rx_dv),
      .wr_en   ((state == PAYLOAD) && rx_dv),
      .wr_data (rx_byte),
      .rd_clr  ((state == CHK) && rx_dv),
      .rd_inc  ((state == DRAIN) && handshake),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr),
      .rd_data (rd_data)
   );

   // The buffer is frozen during DRAIN, so gating the read port is enough for stable data.
   assign m_if.m_data = m_if.m_valid ? rd_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_cnt <= '0;
      else if (rx_dv || !in_frame) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= HUNT;
         len          <= '0;
         sum          <= '0;
         m_if.m_valid <= 1'b0;
         m_if.m_last  <= 1'b0;
         frame_err    <= 1'b0;
         err_code     <= '0;
         rx_overrun   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         rx_overrun <= 1'b0;
         if (tmo_hit) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= HUNT;
            busy      <= 1'b0;
         end else begin
            case (state)
               HUNT: begin
                  if (rx_dv && rx_byte == SOF_BYTE) begin
                     state <= LEN;
                     busy  <= 1'b1;
                  end
               end
               LEN: begin
                  if (rx_dv) begin
                     if (len_bad) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_LEN;
                        state     <= HUNT;
                        busy      <= 1'b0;
                     end else begin
                        len   <= rx_byte[PW-1:0];
                        sum   <= rx_byte;
                        state <= PAYLOAD;
                     end
                  end
               end
               PAYLOAD: begin
                  if (rx_dv) begin
                     sum <= sum + rx_byte;
                     if (wr_ptr == len - PW'(1)) state <= CHK;
                  end
               end
               CHK: begin
                  if (rx_dv) begin
                     if (chk_ok) begin
                        state        <= DRAIN;
                        m_if.m_valid <= 1'b1;
                        m_if.m_last  <= (len == PW'(1));
                     end else begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_CHK;
                        state     <= HUNT;
                        busy      <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (rx_dv) rx_overrun <= 1'b1;
                  if (handshake) begin
                     if (m_if.m_last) begin
                        state        <= HUNT;
                        m_if.m_valid <= 1'b0;
                        m_if.m_last  <= 1'b0;
                        busy         <= 1'b0;
                     end else begin
                        m_if.m_last <= ((rd_ptr + PW'(1)) == (len - PW'(1)));
                     end
                  end
               end
               default: begin
                  state <= HUNT;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef UART_FRAME_STATS_EN
   logic good_evt, bad_evt;

   assign good_evt = (state == CHK) && rx_dv && chk_ok;
   assign bad_evt  = tmo_hit
                   || ((state == LEN) && rx_dv && len_bad)
                   || ((state == CHK) && rx_dv && !chk_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         if (good_evt && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
         if (bad_evt && bad_cnt != '1)   bad_cnt  <= bad_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx.
module tb_uart_frame_rx;

   localparam int unsigned TMO = 17360;

   typedef logic [7:0] bq_t [$];

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_byte;
   logic       rx_dv;
   logic       frame_err;
   logic [1:0] err_code;
   logic       rx_overrun;
   logic       busy;
`ifdef UART_FRAME_STATS_EN
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;
`endif

   uart_frame_rx_if bus ();

   uart_frame_rx #(
      .MAX_LEN      (16),
      .SOF_BYTE     (8'hA5),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_byte    (rx_byte),
      .rx_dv      (rx_dv),
      .m_if       (bus),
      .frame_err  (frame_err),
      .err_code   (err_code),
      .rx_overrun (rx_overrun),
      .busy       (busy)
`ifdef UART_FRAME_STATS_EN
      ,
      .good_cnt   (good_cnt),
      .bad_cnt    (bad_cnt)
`endif
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int err_pulses  = 0;
   int ovr_pulses  = 0;
   int xfers       = 0;

   // Event counters, sampled mid-low-phase once the bench's inputs have settled.
   always @(negedge clk) begin
      #2;
      if (frame_err === 1'b1) err_pulses++;
      if (rx_overrun === 1'b1) ovr_pulses++;
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) xfers++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_byte = b;
      rx_dv   = 1'b1;
      @(negedge clk);
      rx_dv   = 1'b0;
   endtask

   task automatic send_q(input bq_t q);
      foreach (q[i]) send(q[i]);
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic l);
      check({tag, "_valid"}, 16'(bus.m_valid), 16'(v));
      check({tag, "_data"},  16'(bus.m_data),  16'(d));
      check({tag, "_last"},  16'(bus.m_last),  16'(l));
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ferr"},  16'(frame_err),  16'h0);
      check({tag, "_ecode"}, 16'(err_code),   16'h0);
      check({tag, "_ovr"},   16'(rx_overrun), 16'h0);
      check({tag, "_busy"},  16'(busy),       16'h0);
      check_out(tag, 1'b0, 8'h00, 1'b0);
   endtask

   bq_t q;
   logic [7:0] bp_exp [3];
   int x0, e0, o0, k;

   initial begin
      rst_n       = 1'b0;
      rx_dv       = 1'b0;
      rx_byte     = '0;
      bus.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;

      // Good frame, always ready
      bus.m_ready = 1'b1;
      q = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
      send_q(q);
      check_out("good0", 1'b1, 8'h01, 1'b0);
      check("good0_busy", 16'(busy), 16'h1);
      @(negedge clk); check_out("good1", 1'b1, 8'h02, 1'b0);
      @(negedge clk); check_out("good2", 1'b1, 8'h03, 1'b1);
      @(negedge clk); check_out("good_end", 1'b0, 8'h00, 1'b0);
      check("good_end_busy", 16'(busy), 16'h0);
      #3;
      check("good_xfers", 16'(xfers), 16'd3);
      check("good_errs", 16'(err_pulses), 16'd0);

      // Backpressure: each byte stalled 5 cycles
      bp_exp = '{8'h01, 8'h02, 8'h03};
      bus.m_ready = 1'b0;
      x0 = xfers;
      send_q(q);
      for (int i = 0; i < 3; i++) begin
         repeat (5) begin
            check_out("bp_hold", 1'b1, bp_exp[i], (i == 2));
            @(negedge clk);
         end
         bus.m_ready = 1'b1;
         @(negedge clk);
         bus.m_ready = 1'b0;
      end
      check_out("bp_end", 1'b0, 8'h00, 1'b0);
      check("bp_end_busy", 16'(busy), 16'h0);
      #3;
      check("bp_xfers", 16'(xfers - x0), 16'd3);

      // Bad checksum (02+10+20 = 32, sent 31), then a good 1-byte frame
      bus.m_ready = 1'b1;
      x0 = xfers;
      e0 = err_pulses;
      q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      send_q(q);
      check("chk_ferr", 16'(frame_err), 16'h1);
      check("chk_ecode", 16'(err_code), 16'h2);
      check("chk_busy", 16'(busy), 16'h0);
      check("chk_valid", 16'(bus.m_valid), 16'h0);
      @(negedge clk);
      check("chk_ferr_pulse", 16'(frame_err), 16'h0);
      q = '{8'hA5, 8'h01, 8'h7F, 8'h80};
      send_q(q);
      check_out("one0", 1'b1, 8'h7F, 1'b1);
      @(negedge clk); check_out("one_end", 1'b0, 8'h00, 1'b0);
      check("one_ecode_hold", 16'(err_code), 16'h2);
      #3;
      check("chk_xfers", 16'(xfers - x0), 16'd1);
      check("chk_errs", 16'(err_pulses - e0), 16'd1);

      // Bad lengths 00 and 11
      e0 = err_pulses;
      send(8'hA5); send(8'h00);
      check("len0_ferr", 16'(frame_err), 16'h1);
      check("len0_ecode", 16'(err_code), 16'h1);
      check("len0_busy", 16'(busy), 16'h0);
      send(8'hA5); send(8'h11);
      check("len17_ferr", 16'(frame_err), 16'h1);
      check("len17_ecode", 16'(err_code), 16'h1);
      check("len17_busy", 16'(busy), 16'h0);
      #3;
      check("len_errs", 16'(err_pulses - e0), 16'd2);

      // Maximum length frame: 16 bytes 00..0F, checksum 10+78 = 88
      q.delete();
      q.push_back(8'hA5);
      q.push_back(8'h10);
      for (int i = 0; i < 16; i++) q.push_back(8'(i));
      q.push_back(8'h88);
      send_q(q);
      for (int i = 0; i < 16; i++) begin
         check_out("max", 1'b1, 8'(i), (i == 15));
         @(negedge clk);
      end
      check_out("max_end", 1'b0, 8'h00, 1'b0);

      // Timeout after a partial frame
      e0 = err_pulses;
      q = '{8'hA5, 8'h02, 8'h55};
      send_q(q);
      k = 0;
      while (k < int'(TMO) + 20) begin
         @(negedge clk);
         k++;
         if (frame_err === 1'b1) break;
      end
      check("tmo_cycles", 16'(k), 16'(TMO));
      check("tmo_ecode", 16'(err_code), 16'h3);
      check("tmo_busy", 16'(busy), 16'h0);
      send(8'h33);
      check("noise_busy", 16'(busy), 16'h0);
      check("noise_ferr", 16'(frame_err), 16'h0);
      #3;
      check("tmo_errs", 16'(err_pulses - e0), 16'd1);

      // Overrun while stalled, and on the final handshake cycle (02+AA+BB = 67)
      bus.m_ready = 1'b0;
      o0 = ovr_pulses;
      q = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h67};
      send_q(q);
      check_out("ovr_pre", 1'b1, 8'hAA, 1'b0);
      send(8'h44);
      check("ovr_pulse", 16'(rx_overrun), 16'h1);
      check_out("ovr_hold", 1'b1, 8'hAA, 1'b0);
      check("ovr_busy", 16'(busy), 16'h1);
      @(negedge clk);
      check("ovr_pulse_end", 16'(rx_overrun), 16'h0);
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      check_out("ovr_b1", 1'b1, 8'hBB, 1'b1);
      rx_byte     = 8'h44;
      rx_dv       = 1'b1;
      bus.m_ready = 1'b1;
      @(negedge clk);
      rx_dv = 1'b0;
      check("ovr_last_pulse", 16'(rx_overrun), 16'h1);
      check_out("ovr_end", 1'b0, 8'h00, 1'b0);
      check("ovr_end_busy", 16'(busy), 16'h0);
      #3;
      check("ovr_count", 16'(ovr_pulses - o0), 16'd2);

      // Reset mid-payload, then a good frame (02+05+06 = 0D)
      q = '{8'hA5, 8'h04, 8'h01, 8'h02};
      send_q(q);
      check("rst_pre_busy", 16'(busy), 16'h1);
      #3 rst_n = 1'b0;
      #1 check_idle("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      q = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'h0D};
      send_q(q);
      check_out("post0", 1'b1, 8'h05, 1'b0);
      @(negedge clk); check_out("post1", 1'b1, 8'h06, 1'b1);
      @(negedge clk); check_out("post_end", 1'b0, 8'h00, 1'b0);
      check("post_ferr", 16'(frame_err), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
